// File: rtl/cu_sequencer_pkg.sv
// rtl/cu_sequencer_pkg.sv - opcodes, condition codes, FSM states and default widths for cu_sequencer
package cu_sequencer_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_REG_SEL_W   = 4;
    localparam int DEF_STACK_DEPTH = 4;

    // Opcodes 0000..OP_ALU_MAX pass straight through to the ALU
    localparam logic [3:0] OP_ALU_MAX = 4'b0101;
    localparam logic [3:0] OP_C_REG   = 4'b1000;
    localparam logic [3:0] OP_REG_A   = 4'b1001;
    localparam logic [3:0] OP_REG_B   = 4'b1010;
    localparam logic [3:0] OP_RAM_AB  = 4'b1100;
    localparam logic [3:0] OP_LOAD    = 4'b1101;
    localparam logic [3:0] OP_SAVE    = 4'b1110;
    localparam logic [3:0] OP_FLOW    = 4'b1111;

    localparam logic [3:0] CC_JMP  = 4'b0000;
    localparam logic [3:0] CC_OVF  = 4'b0001;
    localparam logic [3:0] CC_UNF  = 4'b0010;
    localparam logic [3:0] CC_SAME = 4'b0011;
    localparam logic [3:0] CC_ABIG = 4'b0100;
    localparam logic [3:0] CC_BBIG = 4'b0101;
    localparam logic [3:0] CC_CALL = 4'b1000;
    localparam logic [3:0] CC_RET  = 4'b1001;
    localparam logic [3:0] CC_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

endpackage

// File: rtl/cu_call_stack.sv
// rtl/cu_call_stack.sv - parametrised LIFO holding return addresses for CALL/RET
module cu_call_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]   mem [DEPTH];
    logic [SPW-1:0] sp;

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = mem[IW'(sp - SPW'(1))];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IW'(sp)] <= din;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - fetch/execute control unit with valid/ready program fetch and call stack
module cu_sequencer
    import cu_sequencer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int REG_SEL_W   = DEF_REG_SEL_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [15:0]          imem_data,
    input  logic                 imem_valid,
    output logic [3:0]           alu_instruction,
    output logic [1:0]           alu_register_enable,
    output logic [REG_SEL_W-1:0] register_select,
    output logic                 register_write,
    output logic                 register_read,
    output logic [1:0]           register_enable,
    output logic [7:0]           ram_address,
    output logic [1:0]           ram_cu_select,
    output logic [DATA_W-1:0]    output_data,
    output logic                 output_valid,
    input  logic                 overflow,
    input  logic                 underflow,
    input  logic                 A_bigger,
    input  logic                 B_bigger,
    input  logic                 AB_same,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted,
    output logic                 stack_error
);

    state_t            state, state_nxt;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] pc_nxt, pc_inc, target, stack_dout;
    logic              push, pop, err_set, stack_full, stack_empty;
    logic [3:0]        opcode, cc;

    assign opcode    = ir[15:12];
    assign cc        = ir[3:0];
    assign pc_inc    = pc + ADDR_W'(1);
    assign target    = ADDR_W'(ir[11:4]);
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);

    cu_call_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stack_dout),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= '0;
            ir          <= '0;
            stack_error <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == ST_FETCH && enable && imem_valid) begin
                ir <= imem_data;
            end
            if (err_set) begin
                stack_error <= 1'b1;
            end
        end
    end

    // Control outputs are decoded only in an enabled EXEC cycle, so they pulse for exactly one cycle
    always_comb begin
        state_nxt           = state;
        pc_nxt              = pc;
        push                = 1'b0;
        pop                 = 1'b0;
        err_set             = 1'b0;
        imem_req            = (state == ST_FETCH) && enable && !reset;
        alu_instruction     = '0;
        alu_register_enable = '0;
        register_select     = '0;
        register_write      = 1'b0;
        register_read       = 1'b0;
        register_enable     = '0;
        ram_address         = '0;
        ram_cu_select       = '0;
        output_data         = '0;
        output_valid        = 1'b0;
        case (state)
            ST_FETCH: begin
                if (enable && imem_valid) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (enable) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = pc_inc;
                    if (opcode <= OP_ALU_MAX) begin
                        alu_instruction = opcode;
                    end else begin
                        case (opcode)
                            OP_C_REG: begin
                                register_write  = 1'b1;
                                register_select = REG_SEL_W'(ir[3:0]);
                                register_enable = 2'b01;
                            end
                            OP_REG_A, OP_REG_B: begin
                                register_read       = 1'b1;
                                register_select     = REG_SEL_W'(ir[3:0]);
                                register_enable     = 2'b01;
                                alu_register_enable = (opcode == OP_REG_A) ? 2'b01 : 2'b10;
                            end
                            OP_RAM_AB: begin
                                ram_address         = ir[11:4];
                                alu_register_enable = ir[1:0];
                                register_enable     = 2'b10;
                                register_read       = 1'b1;
                            end
                            OP_LOAD: begin
                                output_data  = DATA_W'(ir[11:4]);
                                output_valid = 1'b1;
                            end
                            OP_SAVE: begin
                                ram_address     = ir[11:4];
                                register_enable = 2'b10;
                                register_write  = 1'b1;
                                ram_cu_select   = ir[1:0];
                            end
                            OP_FLOW: begin
                                case (cc)
                                    CC_JMP:  pc_nxt = target;
                                    CC_OVF:  if (overflow)  pc_nxt = target;
                                    CC_UNF:  if (underflow) pc_nxt = target;
                                    CC_SAME: if (AB_same)   pc_nxt = target;
                                    CC_ABIG: if (A_bigger)  pc_nxt = target;
                                    CC_BBIG: if (B_bigger)  pc_nxt = target;
                                    CC_CALL: begin
                                        if (stack_full) begin
                                            err_set   = 1'b1;
                                            state_nxt = ST_HALT;
                                            pc_nxt    = pc;
                                        end else begin
                                            push   = 1'b1;
                                            pc_nxt = target;
                                        end
                                    end
                                    CC_RET: begin
                                        if (stack_empty) begin
                                            err_set   = 1'b1;
                                            state_nxt = ST_HALT;
                                            pc_nxt    = pc;
                                        end else begin
                                            pop    = 1'b1;
                                            pc_nxt = stack_dout;
                                        end
                                    end
                                    CC_HALT: begin
                                        state_nxt = ST_HALT;
                                        pc_nxt    = pc;
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - directed vector bench for cu_sequencer
module tb_cu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0;
    logic        imem_valid = 1'b0;
    logic [3:0]  alu_instruction;
    logic [1:0]  alu_register_enable;
    logic [3:0]  register_select;
    logic        register_write, register_read;
    logic [1:0]  register_enable;
    logic [7:0]  ram_address;
    logic [1:0]  ram_cu_select;
    logic [7:0]  output_data;
    logic        output_valid;
    logic        overflow = 1'b0, underflow = 1'b0, A_bigger = 1'b0, B_bigger = 1'b0, AB_same = 1'b0;
    logic [7:0]  pc;
    logic        halted, stack_error;

    always #5 clk = ~clk;

    cu_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
        .alu_instruction(alu_instruction), .alu_register_enable(alu_register_enable),
        .register_select(register_select), .register_write(register_write),
        .register_read(register_read), .register_enable(register_enable),
        .ram_address(ram_address), .ram_cu_select(ram_cu_select),
        .output_data(output_data), .output_valid(output_valid),
        .overflow(overflow), .underflow(underflow), .A_bigger(A_bigger),
        .B_bigger(B_bigger), .AB_same(AB_same),
        .pc(pc), .halted(halted), .stack_error(stack_error)
    );

    wire [32:0] obs = {alu_instruction, alu_register_enable, register_select, register_write,
                       register_read, register_enable, ram_address, ram_cu_select,
                       output_data, output_valid};

    localparam logic [32:0] Z = 33'd0;
    localparam logic [4:0]  F_OVF = 5'b10000, F_UNF = 5'b01000, F_AB = 5'b00100,
                            F_BB = 5'b00010, F_SAME = 5'b00001;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [32:0] pk(logic [3:0] alu, logic [1:0] are, logic [3:0] sel,
                                       logic w, logic r, logic [1:0] re, logic [7:0] ram,
                                       logic [1:0] rcs, logic [7:0] od, logic ov);
        return {alu, are, sel, w, r, re, ram, rcs, od, ov};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_req();
        int t = 0;
        #1;
        while (!imem_req && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("fetch_req", imem_req, 1);
    endtask

    task automatic feed(input logic [15:0] instr, input int lat, input logic [4:0] fl,
                        input logic [7:0] exp_addr);
        logic [7:0] a0;
        wait_req();
        chk("fetch_addr", imem_addr, exp_addr);
        a0 = imem_addr;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("wait_hold", {imem_req, imem_addr, obs}, {1'b1, a0, Z});
        end
        imem_data  = instr;
        imem_valid = 1'b1;
        {overflow, underflow, A_bigger, B_bigger, AB_same} = fl;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 16'h0;
    endtask

    task automatic step(input logic [15:0] instr, input int lat, input logic [4:0] fl,
                        input logic [7:0] exp_addr, input logic [32:0] exp_out,
                        input logic [7:0] exp_pc, input bit do_pc);
        feed(instr, lat, fl, exp_addr);
        chk($sformatf("exec_out_%04h", instr), obs, exp_out);
        @(negedge clk);
        {overflow, underflow, A_bigger, B_bigger, AB_same} = 5'b0;
        chk($sformatf("after_clear_%04h", instr), obs, Z);
        if (do_pc) chk($sformatf("next_pc_%04h", instr), pc, exp_pc);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b1;
        imem_valid = 1'b0;
        {overflow, underflow, A_bigger, B_bigger, AB_same} = 5'b0;
        @(negedge clk);
        chk("reset_state", {imem_req, pc, halted, stack_error, obs}, 64'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  fl;
        logic [32:0] exp_out;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cur;
        tbl[0]  = '{16'h1000, 5'b0,     pk(4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0),                 8'h01};
        tbl[1]  = '{16'h8003, 5'b0,     pk(0, 0, 4'h3, 1, 0, 2'b01, 0, 0, 0, 0),             8'h02};
        tbl[2]  = '{16'h9007, 5'b0,     pk(0, 2'b01, 4'h7, 0, 1, 2'b01, 0, 0, 0, 0),         8'h03};
        tbl[3]  = '{16'hA00C, 5'b0,     pk(0, 2'b10, 4'hC, 0, 1, 2'b01, 0, 0, 0, 0),         8'h04};
        tbl[4]  = '{16'hC3A2, 5'b0,     pk(0, 2'b10, 0, 0, 1, 2'b10, 8'h3A, 0, 0, 0),        8'h05};
        tbl[5]  = '{16'hD5A0, 5'b0,     pk(0, 0, 0, 0, 0, 0, 0, 0, 8'h5A, 1),                8'h06};
        tbl[6]  = '{16'hE7F1, 5'b0,     pk(0, 0, 0, 1, 0, 2'b10, 8'h7F, 2'b01, 0, 0),        8'h07};
        tbl[7]  = '{16'h7123, 5'b0,     Z, 8'h08};
        tbl[8]  = '{16'hF103, F_SAME,   Z, 8'h10};
        tbl[9]  = '{16'hF203, 5'b11110, Z, 8'h11};
        tbl[10] = '{16'hF401, F_OVF,    Z, 8'h40};
        tbl[11] = '{16'hF502, 5'b10111, Z, 8'h41};
        tbl[12] = '{16'hF604, F_AB,     Z, 8'h60};
        tbl[13] = '{16'hF705, F_BB,     Z, 8'h70};
        tbl[14] = '{16'hFFF0, 5'b0,     Z, 8'hFF};
        tbl[15] = '{16'h6000, 5'b0,     Z, 8'h00};
        tbl[16] = '{16'h5000, 5'b0,     pk(4'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0),                 8'h01};
        tbl[17] = '{16'hF2A6, 5'b11111, Z, 8'h02};
        tbl[18] = '{16'hB123, 5'b0,     Z, 8'h03};

        // Table: decode of every opcode class, conditional jumps, pc wrap
        do_reset();
        cur = 8'h00;
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].instr, i % 3, tbl[i].fl, cur, tbl[i].exp_out, tbl[i].exp_pc, 1'b1);
            cur = tbl[i].exp_pc;
        end

        // ADD, LOAD 0x5A, HALT with 3-cycle fetch latency
        do_reset();
        step(16'h1000, 3, 5'b0, 8'h00, pk(4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1'b1);
        step(16'hD5A0, 3, 5'b0, 8'h01, pk(0, 0, 0, 0, 0, 0, 0, 0, 8'h5A, 1), 8'h02, 1'b1);
        step(16'hF00F, 3, 5'b0, 8'h02, Z, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("halt_state", {imem_req, halted, stack_error}, 3'b010);

        // CALL/RET, LIFO ordering, then stack overflow
        do_reset();
        step(16'hF030, 0, 5'b0, 8'h00, Z, 8'h03, 1'b1);
        step(16'hF208, 0, 5'b0, 8'h03, Z, 8'h20, 1'b1);
        step(16'hF009, 1, 5'b0, 8'h20, Z, 8'h04, 1'b1);
        step(16'hF208, 0, 5'b0, 8'h04, Z, 8'h20, 1'b1);
        step(16'hF308, 0, 5'b0, 8'h20, Z, 8'h30, 1'b1);
        step(16'hF009, 0, 5'b0, 8'h30, Z, 8'h21, 1'b1);
        step(16'hF009, 0, 5'b0, 8'h21, Z, 8'h05, 1'b1);
        step(16'hF208, 0, 5'b0, 8'h05, Z, 8'h20, 1'b1);
        for (int k = 0; k < 3; k++) step(16'hF208, 1, 5'b0, 8'h20, Z, 8'h20, 1'b1);
        chk("stack_ok_when_full", {halted, stack_error}, 2'b00);
        step(16'hF208, 0, 5'b0, 8'h20, Z, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        chk("overflow_halt", {imem_req, halted, stack_error}, 3'b011);

        // RET on empty stack
        do_reset();
        step(16'hF009, 0, 5'b0, 8'h00, Z, 8'h00, 1'b0);
        chk("underflow_halt", {imem_req, halted, stack_error}, 3'b011);

        // enable=0 freezes fetch and execute
        do_reset();
        wait_req();
        enable = 1'b0;
        #1;
        chk("disabled_req", imem_req, 0);
        imem_data  = 16'hD5A0;
        imem_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("disabled_fetch_ignored", {pc, obs}, {8'h00, Z});
        imem_valid = 1'b0;
        enable     = 1'b1;
        feed(16'h1000, 0, 5'b0, 8'h00);
        enable = 1'b0;
        #1;
        chk("disabled_exec_out", obs, Z);
        @(negedge clk);
        chk("disabled_exec_hold", {pc, obs}, {8'h00, Z});
        enable = 1'b1;
        #1;
        chk("reenabled_exec_out", obs, pk(4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("reenabled_pc", pc, 8'h01);

        // Reset mid-fetch with a stale imem_valid one cycle later
        do_reset();
        step(16'h1000, 0, 5'b0, 8'h00, pk(4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1'b1);
        wait_req();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {imem_req, pc, obs}, {1'b0, 8'h00, Z});
        @(negedge clk);
        imem_data  = 16'hD5A0;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("stale_ignored", {pc, obs}, {8'h00, Z});
        reset = 1'b0;
        step(16'h4000, 0, 5'b0, 8'h00, pk(4'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
